// File: rtl/csa_mul_iter_32_if.sv
// Operand/result bundle between the issuing stage and csa_mul_iter_32.
// master drives operands, slave returns the carry-save result.
interface csa_mul_iter_32_if;
    logic        v_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        ready_out;
    logic [31:0] sum_out;
    logic [31:0] carry_out;
    logic        v_out;

    modport master (
        output v_in, a_in, b_in,
        input  ready_out, sum_out, carry_out, v_out
    );

    modport slave (
        input  v_in, a_in, b_in,
        output ready_out, sum_out, carry_out, v_out
    );
endinterface

// File: rtl/csa_mul_iter_32.sv
// Iterative shift-and-add multiplier front end, carry-save result (low 32 bits).
// CSA_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
module csa_mul_iter_32 #(
    parameter int BPC = 4
) (
    input logic              clk,
    input logic              rst,
    csa_mul_iter_32_if.slave bus
);
    localparam int N = 32 / BPC;

    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8)) begin : g_bad_bpc
        $error("csa_mul_iter_32: BPC must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc_s;
    logic [31:0] acc_c;
    logic [31:0] s_nx;
    logic [31:0] c_nx;
    logic [31:0] cp_s;
    logic [31:0] cp_c;
    logic [31:0] sum_q;
    logic [31:0] carry_q;
    logic        accept;
    logic        finish;
    logic        step;

    assign accept = bus.v_in && (state != RUN);

    // 3:2 chain over {acc_s, acc_c<<1, pp_0..pp_BPC-1}; carry kept unshifted
    always_comb begin
        logic [31:0] s;
        logic [31:0] cs;
        logic [31:0] pp;
        logic [31:0] maj;
        s   = acc_s;
        cs  = acc_c << 1;
        pp  = '0;
        maj = '0;
        for (int k = 0; k < BPC; k++) begin
            pp  = mplier[k] ? (mcand << k) : '0;
            maj = (s & cs) | (s & pp) | (cs & pp);
            s   = s ^ cs ^ pp;
            cs  = maj << 1;
        end
        s_nx = s;
        c_nx = maj;
    end

`ifdef CSA_MUL_EARLY_EXIT_EN
    // Exit cycle does no accumulation, so the stored acc is the result
    assign finish = (mplier == '0);
    assign step   = !finish;
    assign cp_s   = acc_s;
    assign cp_c   = acc_c;
`else
    logic [5:0] iter;
    assign finish = (iter == 6'(N - 1));
    assign step   = 1'b1;
    assign cp_s   = s_nx;
    assign cp_c   = c_nx;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (finish) state_nx = DONE;
            DONE:    state_nx = accept ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc_s   <= '0;
            acc_c   <= '0;
            sum_q   <= '0;
            carry_q <= '0;
`ifndef CSA_MUL_EARLY_EXIT_EN
            iter    <= '0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                mcand  <= bus.a_in;
                mplier <= bus.b_in;
                acc_s  <= '0;
                acc_c  <= '0;
`ifndef CSA_MUL_EARLY_EXIT_EN
                iter   <= '0;
`endif
            end else if (state == RUN) begin
                if (finish) begin
                    sum_q   <= cp_s;
                    carry_q <= cp_c;
                end
                if (step) begin
                    acc_s  <= s_nx;
                    acc_c  <= c_nx;
                    mcand  <= mcand << BPC;
                    mplier <= mplier >> BPC;
`ifndef CSA_MUL_EARLY_EXIT_EN
                    iter   <= iter + 6'd1;
`endif
                end
            end
        end
    end

    assign bus.ready_out = (state != RUN);
    assign bus.v_out     = (state == DONE);
    assign bus.sum_out   = sum_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_csa_mul_iter_32.sv
// Directed bench for csa_mul_iter_32 at BPC=4, with BPC=1 and BPC=8 copies.
// Honours CSA_MUL_EARLY_EXIT_EN when computing expected latencies.
module tb_csa_mul_iter_32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v_alt = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    csa_mul_iter_32_if bus4 ();
    csa_mul_iter_32_if bus1 ();
    csa_mul_iter_32_if bus8 ();

    assign bus1.v_in = v_alt;
    assign bus1.a_in = bus4.a_in;
    assign bus1.b_in = bus4.b_in;
    assign bus8.v_in = v_alt;
    assign bus8.a_in = bus4.a_in;
    assign bus8.b_in = bus4.b_in;

    csa_mul_iter_32 #(.BPC(4)) dut (.clk(clk), .rst(rst), .bus(bus4.slave));
    csa_mul_iter_32 #(.BPC(1)) u1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    csa_mul_iter_32 #(.BPC(8)) u8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fold(input logic [31:0] s,
                                         input logic [31:0] c);
        return s + (c << 1);
    endfunction

    function automatic int exp_lat(input logic [31:0] b, input int bpc);
        int m;
        m = -1;
        for (int i = 0; i < 32; i++) if (b[i]) m = i;
`ifdef CSA_MUL_EARLY_EXIT_EN
        return 2 + (m + bpc) / bpc;
`else
        return (m < 32) ? 32 / bpc + 1 : 0;
`endif
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
        @(negedge clk);
        bus4.v_in = 1'b1;
        bus4.a_in = a;
        bus4.b_in = b;
        @(posedge clk);
        #1;
        bus4.v_in = 1'b0;
        lat = 1;
        while (!bus4.v_out && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = fold(bus4.sum_out, bus4.carry_out);
    endtask

    localparam int NV = 10;
    logic [31:0] va [NV] = '{32'd7, 32'hFFFFFFFF, 32'h12345678, 32'h00010000,
                             32'd3, 32'hFFFFFFFF, 32'h00001234, 32'd0,
                             32'hDEADBEEF, 32'h0000FFFF};
    logic [31:0] vb [NV] = '{32'd6, 32'hFFFFFFFF, 32'h9ABCDEF0, 32'h00010000,
                             32'h80000000, 32'd2, 32'd1, 32'hDEADBEEF,
                             32'd0, 32'h0000FFFF};
    logic [31:0] vr [NV] = '{32'd42, 32'h00000001, 32'h242D2080, 32'h0,
                             32'h80000000, 32'hFFFFFFFE, 32'h00001234, 32'h0,
                             32'h0, 32'hFFFE0001};

    initial begin
        int          lat;
        int          lat1;
        int          lat8;
        int          np;
        int          cyc;
        int          pulse_at [2];
        logic [31:0] res;
        logic [31:0] r1;
        logic [31:0] r8;
        logic [31:0] pres [2];

        bus4.v_in = 1'b0;
        bus4.a_in = '0;
        bus4.b_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(bus4.ready_out), 32'd1);
        check("rst_vout", 32'(bus4.v_out), 32'd0);
        check("rst_sum", bus4.sum_out, 32'd0);
        check("rst_carry", bus4.carry_out, 32'd0);

        // back-to-back: each op after the first is accepted in DONE
        for (int i = 0; i < NV; i++) begin
            run_op(va[i], vb[i], lat, res);
            check($sformatf("res%0d", i), res, vr[i]);
            check($sformatf("lat%0d", i), 32'(lat), 32'(exp_lat(vb[i], 4)));
        end

        @(negedge clk);
        bus4.a_in = 32'h12345678;
        bus4.b_in = 32'h9ABCDEF0;
        v_alt = 1'b1;
        @(posedge clk);
        #1;
        v_alt = 1'b0;
        lat1 = 0;
        lat8 = 0;
        r1 = '0;
        r8 = '0;
        for (int t = 1; t <= 60; t++) begin
            if (bus1.v_out && lat1 == 0) begin
                lat1 = t;
                r1 = fold(bus1.sum_out, bus1.carry_out);
            end
            if (bus8.v_out && lat8 == 0) begin
                lat8 = t;
                r8 = fold(bus8.sum_out, bus8.carry_out);
            end
            @(posedge clk);
            #1;
        end
        check("bpc1_res", r1, 32'h242D2080);
        check("bpc1_lat", 32'(lat1), 32'(exp_lat(32'h9ABCDEF0, 1)));
        check("bpc8_res", r8, 32'h242D2080);
        check("bpc8_lat", 32'(lat8), 32'(exp_lat(32'h9ABCDEF0, 8)));

        // v_in held high; operands change while busy and must be ignored
        @(negedge clk);
        bus4.v_in = 1'b1;
        bus4.a_in = 32'd2;
        bus4.b_in = 32'd3;
        np = 0;
        pulse_at[0] = 0;
        pulse_at[1] = 0;
        pres[0] = '0;
        pres[1] = '0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 2) begin
                check("hold_busy", 32'(bus4.ready_out), 32'd0);
                bus4.a_in = 32'd5;
                bus4.b_in = 32'd5;
            end
            if (bus4.v_out) begin
                if (np < 2) begin
                    pulse_at[np] = cyc;
                    pres[np] = fold(bus4.sum_out, bus4.carry_out);
                end
                np++;
                if (np == 2) bus4.v_in = 1'b0;
            end
        end
        bus4.v_in = 1'b0;
        check("hold_npulse", 32'(np), 32'd2);
        check("hold_res0", pres[0], 32'd6);
        check("hold_res1", pres[1], 32'd25);
        check("hold_first", 32'(pulse_at[0]), 32'(exp_lat(32'd3, 4)));
        check("hold_gap", 32'(pulse_at[1] - pulse_at[0]),
              32'(exp_lat(32'd5, 4)));

        // abort: reset 4 cycles into an op, with v_in also high
        @(negedge clk);
        bus4.v_in = 1'b1;
        bus4.a_in = 32'h12345678;
        bus4.b_in = 32'h9ABCDEF0;
        @(posedge clk);
        #1;
        bus4.v_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus4.v_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus4.v_in = 1'b0;
        check("abort_ready", 32'(bus4.ready_out), 32'd1);
        check("abort_vout", 32'(bus4.v_out), 32'd0);
        check("abort_sum", bus4.sum_out, 32'd0);
        check("abort_carry", bus4.carry_out, 32'd0);
        np = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus4.v_out) np++;
        end
        check("abort_nopulse", 32'(np), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
